pipe_stage_reg: RTL

- Parametrised, handshaked pipeline stage register. It is the generic successor to the fixed D→E stage register.
- Carries separate control and data payloads with a valid bit, and applies valid/ready back-pressure through an optional 2-entry skid buffer.
- Supports synchronous flush for bubble insertion on branch or hazard.
- Counts bubbles for performance monitoring.
- One instance sits between each pair of pipeline stages (F/D, D/E, E/M, M/W).

---
 rtl/pipe_stage_reg.sv | 116 +++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register: main entry plus optional skid entry, 1-cycle latency when empty.
// SKID=1 gives registered in_ready (no out_ready->in_ready path); SKID=0 stalls upstream combinationally.
module pipe_stage_reg #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 160,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              m_valid_q, m_valid_d;
  logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;
  logic              s_valid_q, s_valid_d;
  logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
  logic [DATA_W-1:0] s_data_q,  s_data_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic              in_fire;
  logic              drain;

  always_comb begin
    if (SKID != 0) in_ready = !s_valid_q;
    else           in_ready = out_ready || !m_valid_q;
  end

  assign in_fire = in_valid && in_ready;
  assign drain   = !m_valid_q || out_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    m_ctrl_d  = m_ctrl_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_ctrl_d  = s_ctrl_q;
    s_data_d  = s_data_q;
    if (flush) begin
      // Data registers hold on flush; only valid and control are cleared.
      m_valid_d = 1'b0;
      m_ctrl_d  = '0;
      s_valid_d = 1'b0;
      s_ctrl_d  = '0;
    end else if (SKID != 0) begin
      if (drain) begin
        if (s_valid_q) begin
          m_valid_d = 1'b1;
          m_ctrl_d  = s_ctrl_q;
          m_data_d  = s_data_q;
          s_valid_d = 1'b0;
          s_ctrl_d  = '0;
        end else if (in_fire) begin
          m_valid_d = 1'b1;
          m_ctrl_d  = in_ctrl;
          m_data_d  = in_data;
        end else begin
          m_valid_d = 1'b0;
          m_ctrl_d  = '0;
        end
      end else if (in_fire) begin
        s_valid_d = 1'b1;
        s_ctrl_d  = in_ctrl;
        s_data_d  = in_data;
      end
    end else if (in_ready) begin
      m_valid_d = in_valid;
      m_ctrl_d  = in_valid ? in_ctrl : '0;
      if (in_valid) m_data_d = in_data;
    end
  end

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (!flush && out_ready && !m_valid_q && (bubble_cnt_q != '1))
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_valid_q    <= 1'b0;
      m_ctrl_q     <= '0;
      m_data_q     <= '0;
      s_valid_q    <= 1'b0;
      s_ctrl_q     <= '0;
      s_data_q     <= '0;
      bubble_cnt_q <= '0;
    end else begin
      m_valid_q    <= m_valid_d;
      m_ctrl_q     <= m_ctrl_d;
      m_data_q     <= m_data_d;
      s_valid_q    <= s_valid_d;
      s_ctrl_q     <= s_ctrl_d;
      s_data_q     <= s_data_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // Bubbles must never present live control fields downstream.
  assign out_valid  = m_valid_q;
  assign out_ctrl   = m_valid_q ? m_ctrl_q : '0;
  assign out_data   = m_data_q;
  assign occupancy  = 2'(m_valid_q) + 2'(s_valid_q);
  assign bubble_cnt = bubble_cnt_q;

endmodule
